mult_operand_feeder: RTL and testbench

//  Upstream feeder for the 16x16 multiplier stage. Buffers operand pairs from the bus side
//  in a small FIFO, issues one start pulse per pair to the multiplier and captures its 32-bit

---
 rtl/mult_operand_feeder.sv | 180 ++++++++++++++++++
 tb/tb_mult_operand_feeder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_operand_feeder.sv
// Operand FIFO + issue/wait/hold sequencer feeding a 16x16 multiplier; results return in order.
// Optional statistics ports (op_count, err_count) are enabled by defining MULT_FEEDER_STATS_EN.
module mult_operand_feeder #(
    parameter int DEPTH    = 4,
    parameter int MULT_LAT = 1,
    parameter int TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        mult_start,
    output logic [15:0] mult_a,
    output logic [15:0] mult_b,
    input  logic [31:0] mult_c,
    input  logic        mult_calculated,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err
`ifdef MULT_FEEDER_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [7:0]  err_count
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] LAT_CNT   = WAIT_W'(MULT_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [15:0]       r_fifo_a [DEPTH];
    logic [15:0]       r_fifo_b [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [15:0]       r_mult_a;
    logic [15:0]       r_mult_b;
    logic [31:0]       r_res_data;
    logic              r_res_err;

    logic w_full, w_empty, w_push, w_pop;
    logic w_load, w_start, w_capture, w_timeout, w_lat_ok;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = op_valid && !w_full;
    // r_wait_cnt is 0 in the first WAIT cycle, so cnt+1 cycles have elapsed since the start pulse
    assign w_lat_ok = (r_wait_cnt >= LAT_CNT);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_a[r_wptr] <= op_a;
            r_fifo_b[r_wptr] <= op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start     = 1'b0;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // operands are latched here so they are already stable during the start pulse
                if (!w_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start     = 1'b1;
                w_pop       = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_lat_ok && mult_calculated) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HOLD;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= '0;
            r_mult_a   <= '0;
            r_mult_b   <= '0;
            r_res_data <= '0;
            r_res_err  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_mult_a <= r_fifo_a[r_rptr];
                r_mult_b <= r_fifo_b[r_rptr];
            end
            if (r_state == S_ISSUE)
                r_wait_cnt <= '0;
            else if (r_state == S_WAIT)
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            if (w_capture) begin
                r_res_data <= mult_c;
                r_res_err  <= 1'b0;
            end else if (w_timeout) begin
                r_res_data <= '0;
                r_res_err  <= 1'b1;
            end
        end
    end

    assign op_ready   = !w_full;
    assign mult_start = w_start;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;
    assign res_valid  = (r_state == S_HOLD);
    assign res_data   = r_res_data;
    assign res_err    = r_res_err;

`ifdef MULT_FEEDER_STATS_EN
    logic [15:0] r_op_count;
    logic [7:0]  r_err_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count  <= '0;
            r_err_count <= '0;
        end else begin
            if ((r_state == S_HOLD) && res_ready && !r_res_err)
                r_op_count <= r_op_count + 16'd1;
            if (w_timeout)
                r_err_count <= sat_inc8(r_err_count);
        end
    end

    assign op_count  = r_op_count;
    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_mult_operand_feeder.sv
// Directed bench for mult_operand_feeder: a default instance with a behavioural multiplier
// and a MULT_LAT=3 instance whose done flag is stuck high.
module tb_mult_operand_feeder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        op_valid, op_ready;
    logic [15:0] op_a, op_b;
    logic        mult_start;
    logic [15:0] mult_a, mult_b;
    logic [31:0] mult_c = 32'd0;
    logic        mult_calculated = 1'b0;
    logic        res_valid, res_ready, res_err;
    logic [31:0] res_data;

    logic        l_op_valid, l_op_ready;
    logic [15:0] l_op_a, l_op_b;
    logic        l_mult_start;
    logic [15:0] l_mult_a, l_mult_b;
    logic [31:0] l_mult_c;
    logic        l_calc;
    logic        l_res_valid, l_res_ready, l_res_err;
    logic [31:0] l_res_data;

`ifdef MULT_FEEDER_STATS_EN
    logic [15:0] op_count, l_op_count;
    logic [7:0]  err_count, l_err_count;
`endif

    int   total = 0;
    int   bad = 0;
    int   start_cnt = 0;
    logic respond;

    mult_operand_feeder u_dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_c(mult_c), .mult_calculated(mult_calculated),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
`ifdef MULT_FEEDER_STATS_EN
        , .op_count(op_count), .err_count(err_count)
`endif
    );

    mult_operand_feeder #(.DEPTH(4), .MULT_LAT(3), .TIMEOUT(64)) u_lat3 (
        .clk(clk), .rst(rst),
        .op_valid(l_op_valid), .op_ready(l_op_ready), .op_a(l_op_a), .op_b(l_op_b),
        .mult_start(l_mult_start), .mult_a(l_mult_a), .mult_b(l_mult_b),
        .mult_c(l_mult_c), .mult_calculated(l_calc),
        .res_valid(l_res_valid), .res_ready(l_res_ready), .res_data(l_res_data), .res_err(l_res_err)
`ifdef MULT_FEEDER_STATS_EN
        , .op_count(l_op_count), .err_count(l_err_count)
`endif
    );

    assign l_mult_c = 32'(l_mult_a) * 32'(l_mult_b);

    // One-cycle multiplier with a sticky done flag; respond=0 models a hung multiplier
    always @(posedge clk) begin
        if (rst) begin
            mult_calculated <= 1'b0;
        end else if (mult_start) begin
            mult_c          <= 32'(mult_a) * 32'(mult_b);
            mult_calculated <= respond;
        end
        if (mult_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int n);
        int k;
        op_valid = 1'b1; op_a = a; op_b = b;
        tick();
        op_valid = 1'b0;
        k = 0;
        while (!mult_start && k < 20) begin tick(); k++; end
        chk("start_seen", {31'b0, mult_start}, 32'd1);
        n = 0;
        while (!res_valid && n < 200) begin tick(); n++; end
    endtask

    task automatic accept(input string tag, input logic [31:0] exp_d, input logic exp_e);
        chk({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
        chk({tag, "_data"}, res_data, exp_d);
        chk({tag, "_err"}, {31'b0, res_err}, {31'b0, exp_e});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    logic [15:0] burst_a [5] = '{16'd7, 16'd11, 16'd13, 16'h1234, 16'h8000};
    logic [15:0] burst_b [5] = '{16'd9, 16'h0100, 16'hFFFF, 16'h0010, 16'd2};
    logic [31:0] burst_e [5] = '{32'd63, 32'h0B00, 32'h000CFFF3, 32'h00012340, 32'h00010000};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, k, extra, sc;
        rst = 1'b1; respond = 1'b1;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        l_op_valid = 1'b0; l_op_a = '0; l_op_b = '0; l_res_ready = 1'b0; l_calc = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        chk("rst_op_ready", {31'b0, op_ready}, 32'd1);
        chk("rst_start", {31'b0, mult_start}, 32'd0);
        chk("rst_mult_a", {16'b0, mult_a}, 32'd0);
        chk("rst_mult_b", {16'b0, mult_b}, 32'd0);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_err", {31'b0, res_err}, 32'd0);

        // single op 3*5, cycle-exact latency
        op_valid = 1'b1; op_a = 16'd3; op_b = 16'd5;
        tick();
        op_valid = 1'b0;
        chk("t1_start", {31'b0, mult_start}, 32'd0);
        tick();
        chk("t2_start", {31'b0, mult_start}, 32'd1);
        chk("t2_mult_a", {16'b0, mult_a}, 32'd3);
        chk("t2_mult_b", {16'b0, mult_b}, 32'd5);
        tick();
        chk("t3_start", {31'b0, mult_start}, 32'd0);
        chk("t3_res_valid", {31'b0, res_valid}, 32'd0);
        tick();
        chk("t4_start_pulses", start_cnt, 32'd1);
        accept("op3x5", 32'd15, 1'b0);
        chk("op3x5_released", {31'b0, res_valid}, 32'd0);

        run_op(16'hFFFF, 16'hFFFF, n);
        chk("max_lat", n, 32'd2);
        accept("max", 32'hFFFE0001, 1'b0);

        // five back-to-back pushes with the result port stalled
        for (int i = 0; i < 5; i++) begin
            op_valid = 1'b1; op_a = burst_a[i]; op_b = burst_b[i];
            chk("burst_op_ready", {31'b0, op_ready}, 32'd1);
            tick();
        end
        op_a = 16'hDEAD; op_b = 16'd1;
        chk("full_op_ready", {31'b0, op_ready}, 32'd0);
        tick();
        chk("full_op_ready2", {31'b0, op_ready}, 32'd0);
        op_valid = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            k = 0;
            while (!res_valid && k < 50) begin tick(); k++; end
            chk("burst_valid", {31'b0, res_valid}, 32'd1);
            chk("burst_data", res_data, burst_e[i]);
            chk("burst_err", {31'b0, res_err}, 32'd0);
            tick();
        end
        res_ready = 1'b0;
        extra = 0;
        repeat (10) begin tick(); extra += int'(res_valid); end
        chk("burst_no_extra", extra, 32'd0);
        chk("burst_drained_ready", {31'b0, op_ready}, 32'd1);

        // hung multiplier -> timeout, then recovery
        respond = 1'b0;
        run_op(16'd4, 16'd4, n);
        chk("timeout_lat", n, 32'd65);
        accept("timeout", 32'd0, 1'b1);
        respond = 1'b1;
        run_op(16'd6, 16'd7, n);
        chk("after_to_lat", n, 32'd2);
        accept("after_to", 32'd42, 1'b0);

        // reset while waiting with two pairs queued
        respond = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op_valid = 1'b1; op_a = 16'd2 + 16'(i); op_b = 16'd3;
            tick();
        end
        op_valid = 1'b0;
        repeat (5) tick();
        sc = start_cnt;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        respond = 1'b1;
        chk("midrst_op_ready", {31'b0, op_ready}, 32'd1);
        chk("midrst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("midrst_mult_a", {16'b0, mult_a}, 32'd0);
        extra = 0;
        repeat (20) begin tick(); extra += int'(res_valid); end
        chk("midrst_no_result", extra, 32'd0);
        chk("midrst_no_start", start_cnt - sc, 32'd0);

`ifdef MULT_FEEDER_STATS_EN
        chk("stats_rst_ops", {16'b0, op_count}, 32'd0);
        chk("stats_rst_errs", {24'b0, err_count}, 32'd0);
`endif
        run_op(16'd2, 16'd3, n);
        accept("s1", 32'd6, 1'b0);
        run_op(16'd0, 16'd9, n);
        accept("s2", 32'd0, 1'b0);
        run_op(16'h0100, 16'h0100, n);
        accept("s3", 32'h00010000, 1'b0);
        respond = 1'b0;
        run_op(16'd1, 16'd1, n);
        accept("s4_to", 32'd0, 1'b1);
        respond = 1'b1;
`ifdef MULT_FEEDER_STATS_EN
        chk("stats_ops", {16'b0, op_count}, 32'd3);
        chk("stats_errs", {24'b0, err_count}, 32'd1);
`endif

        // sticky done flag must be ignored until MULT_LAT cycles after the start pulse
        l_op_valid = 1'b1; l_op_a = 16'd100; l_op_b = 16'd200;
        tick();
        l_op_valid = 1'b0;
        k = 0;
        while (!l_mult_start && k < 20) begin tick(); k++; end
        chk("lat3_start", {31'b0, l_mult_start}, 32'd1);
        n = 0;
        while (!l_res_valid && n < 200) begin tick(); n++; end
        chk("lat3_lat", n, 32'd4);
        chk("lat3_data", l_res_data, 32'd20000);
        chk("lat3_err", {31'b0, l_res_err}, 32'd0);
        l_res_ready = 1'b1;
        tick();
        l_res_ready = 1'b0;
        chk("lat3_released", {31'b0, l_res_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
